// File: rtl/rf_pkg.sv
// rf_pkg: shared bus codes, opcodes and sizes for the rf_processor_core front end
package rf_pkg;
  localparam logic [1:0] BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2;
  localparam logic [1:0] HTRANS_IDLE = 2'b00, HTRANS_NONSEQ = 2'b10;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [2:0] {SZ_BYTE = 3'd0, SZ_HALF = 3'd1, SZ_WORD = 3'd2} size_e;
endpackage

// File: rtl/rf_processor_core_if.sv
// rf_processor_core_if: AHB-Lite data-side bus between the core and data memory
interface rf_processor_core_if;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  modport master(output HADDR, HSIZE, HWRITE, HWDATA, HTRANS, input HRDATA, HREADY, HRESP);
  modport slave(input HADDR, HSIZE, HWRITE, HWDATA, HTRANS, output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/rf_regfile.sv
// rf_regfile: 32x32 register file, two combinational reads, one write, write-to-read bypass
module rf_regfile (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [32];
  // x0 is never written so it stays at its reset value of zero
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0) regs[wa] <= wd;
  assign rd1 = ra1 == 5'd0 ? '0 : we && wa == ra1 ? wd : regs[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : we && wa == ra2 ? wd : regs[ra2];
endmodule

// File: rtl/rf_processor_core.sv
// rf_processor_core: IF -> ID -> RF pipeline front end with an AHB-Lite load/store master
module rf_processor_core
  import rf_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = rf_pkg::NOP_INST
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [31:0]         instruction,
  output logic [31:0]         pc_addr,
  output logic [1:0]          im_command,
  rf_processor_core_if.master ahb,
  output logic [31:0]         if_PC_out,
  output logic [31:0]         if_NPC_out,
  output logic [31:0]         if_IR_out,
  output logic                if_valid_inst_out,
  output logic [31:0]         if_id_PC,
  output logic [31:0]         if_id_NPC,
  output logic [31:0]         if_id_IR,
  output logic                if_id_valid_inst,
  output logic [31:0]         id_rf_PC,
  output logic [31:0]         id_rf_NPC,
  output logic [31:0]         id_rf_IR,
  output logic                id_rf_valid_inst
);
  logic [31:0] pc, imm, ea, addr, rs1_data, rs2_data, wdata, ld_data, dp_wdata;
  logic [15:0] lane;
  logic [4:0]  dp_rd;
  logic [1:0]  sz, dp_sz, dp_lane;
  logic        is_ld, is_st, mem_op, stall, we, dp_v, dp_w, dp_uns;

  assign stall = dp_v & ~ahb.HREADY;
  assign pc_addr = pc;
  assign im_command = HRESETn && !stall ? BUS_LOAD : BUS_NONE;
  assign if_PC_out = pc;
  assign if_NPC_out = pc + 32'd4;
  assign if_IR_out = instruction;
  assign if_valid_inst_out = im_command == BUS_LOAD;

  // PC and both pipeline registers advance together unless a data phase is waiting
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      pc <= RESET_PC;
      {if_id_PC, if_id_NPC, if_id_IR, if_id_valid_inst} <= {64'd0, NOP_INST, 1'b0};
      {id_rf_PC, id_rf_NPC, id_rf_IR, id_rf_valid_inst} <= {64'd0, NOP_INST, 1'b0};
    end else if (!stall) begin
      pc <= pc + 32'd4;
      {if_id_PC, if_id_NPC, if_id_IR, if_id_valid_inst} <= {if_PC_out, if_NPC_out, if_IR_out, if_valid_inst_out};
      {id_rf_PC, id_rf_NPC, id_rf_IR, id_rf_valid_inst} <= {if_id_PC, if_id_NPC, if_id_IR, if_id_valid_inst};
    end

  assign is_ld = id_rf_valid_inst && id_rf_IR[6:0] == OP_LOAD;
  assign is_st = id_rf_valid_inst && id_rf_IR[6:0] == OP_STORE;
  assign mem_op = is_ld | is_st;
  assign sz = id_rf_IR[13:12];
  assign imm = is_st ? {{20{id_rf_IR[31]}}, id_rf_IR[31:25], id_rf_IR[11:7]} : {{20{id_rf_IR[31]}}, id_rf_IR[31:20]};
  assign ea = rs1_data + imm;
  assign addr = {ea[31:2], sz == 2'd0 ? ea[1:0] : sz == 2'd1 ? {ea[1], 1'b0} : 2'b00};
  assign wdata = sz == 2'd0 ? {4{rs2_data[7:0]}} : sz == 2'd1 ? {2{rs2_data[15:0]}} : rs2_data;

  assign ahb.HTRANS = mem_op ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb.HADDR = mem_op ? addr : '0;
  assign ahb.HSIZE = mem_op ? {1'b0, sz} : SZ_WORD;
  assign ahb.HWRITE = is_st;
  assign ahb.HWDATA = dp_wdata;

  // Accepted address phase becomes the data phase; it holds while HREADY is low
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) {dp_v, dp_w, dp_uns, dp_sz, dp_lane, dp_rd, dp_wdata} <= '0;
    else if (!stall) {dp_v, dp_w, dp_uns, dp_sz, dp_lane, dp_rd, dp_wdata} <= {mem_op, is_st, id_rf_IR[14], sz, addr[1:0], id_rf_IR[11:7], wdata};

  assign lane = 16'(ahb.HRDATA >> {dp_lane, 3'b000});
  assign ld_data = dp_sz == 2'd0 ? {{24{~dp_uns & lane[7]}}, lane[7:0]} : dp_sz == 2'd1 ? {{16{~dp_uns & lane[15]}}, lane} : ahb.HRDATA;
  assign we = dp_v & ~dp_w & ahb.HREADY & ~ahb.HRESP;

  rf_regfile u_regfile (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .ra1    (id_rf_IR[19:15]),
    .ra2    (id_rf_IR[24:20]),
    .we     (we),
    .wa     (dp_rd),
    .wd     (ld_data),
    .rd1    (rs1_data),
    .rd2    (rs2_data)
  );
endmodule

// File: tb/tb_rf_processor_core.sv
// tb_rf_processor_core: random load/store program checked against an ISA-level model
module tb_rf_processor_core;
  import rf_pkg::*;
  localparam int NP = 128;
  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic [31:0] instruction, pc_addr;
  logic [1:0]  im_command;
  logic [31:0] if_PC_out, if_NPC_out, if_IR_out, if_id_PC, if_id_NPC, if_id_IR, id_rf_PC, id_rf_NPC, id_rf_IR;
  logic        if_valid_inst_out, if_id_valid_inst, id_rf_valid_inst;
  logic [31:0] prog [NP];
  logic [31:0] mmem [int unsigned];
  logic [31:0] smem [int unsigned];
  logic [31:0] ta [NP], td [NP];
  logic [1:0]  tsz [NP];
  logic        tw [NP], terr [NP];
  logic        stall, dv, seen;
  logic [31:0] pc_exp;
  int ntx, idx, di, done, lows, checks, failures;

  rf_processor_core_if bus();

  rf_processor_core dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .instruction(instruction), .pc_addr(pc_addr), .im_command(im_command), .ahb(bus),
    .if_PC_out(if_PC_out), .if_NPC_out(if_NPC_out), .if_IR_out(if_IR_out), .if_valid_inst_out(if_valid_inst_out),
    .if_id_PC(if_id_PC), .if_id_NPC(if_id_NPC), .if_id_IR(if_id_IR), .if_id_valid_inst(if_id_valid_inst),
    .id_rf_PC(id_rf_PC), .id_rf_NPC(id_rf_NPC), .id_rf_IR(id_rf_IR), .id_rf_valid_inst(id_rf_valid_inst)
  );

  always #5 HCLK = ~HCLK;
  assign instruction = pc_addr[31:9] == 23'd0 ? prog[pc_addr[8:2]] : NOP_INST;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_ir(input logic [31:0] p);
    return p < 32'(NP * 4) ? prog[p[8:2]] : NOP_INST;
  endfunction

  function automatic logic [31:0] init_word(input int unsigned w);
    return w == 0 ? 32'h80FF_0102 : w == 2 ? 32'hDEAD_BEEF : (w * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] mrd(input logic s, input int unsigned w);
    if (s) return smem.exists(w) ? smem[w] : init_word(w);
    return mmem.exists(w) ? mmem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] m;
    m = sz == 2'd0 ? 32'hFF << (8 * a[1:0]) : sz == 2'd1 ? 32'hFFFF << (16 * a[1]) : 32'hFFFF_FFFF;
    return (old & ~m) | (d & m);
  endfunction

  function automatic logic [31:0] enc_ld(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, OP_LOAD};
  endfunction

  function automatic logic [31:0] enc_st(input logic [2:0] f3, input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
  endfunction

  task automatic gen_program();
    int k, f;
    logic [4:0] rs1, rs2, rd;
    logic [11:0] imm;
    prog[0] = enc_ld(3'd2, 5'd5, 5'd0, 12'd8);
    prog[1] = enc_ld(3'd0, 5'd6, 5'd0, 12'd3);
    prog[2] = enc_ld(3'd4, 5'd7, 5'd0, 12'd3);
    prog[3] = enc_st(3'd1, 5'd5, 5'd0, 12'd2);
    prog[4] = enc_ld(3'd2, 5'd1, 5'd0, 12'd0);
    prog[5] = enc_st(3'd2, 5'd6, 5'd0, 12'd16);
    prog[6] = enc_st(3'd2, 5'd7, 5'd0, 12'd20);
    prog[7] = enc_st(3'd2, 5'd1, 5'd0, 12'd24);
    for (int i = 8; i < NP; i++) begin
      k = int'($urandom_range(9));
      f = int'($urandom_range(4));
      rs1 = $urandom_range(1) == 0 ? 5'd0 : 5'($urandom_range(7));
      rs2 = 5'($urandom_range(7));
      rd = 5'($urandom_range(7));
      imm = rs1 == 5'd0 ? 12'($urandom_range(63)) : 12'($urandom);
      prog[i] = k < 4 ? enc_ld(f < 3 ? 3'(f) : 3'(f + 1), rd, rs1, imm)
              : k < 7 ? enc_st(3'($urandom_range(2)), rs2, rs1, imm)
              : k < 8 ? NOP_INST : {imm, rs1, 3'b000, rd, 7'b0010011};
    end
  endtask

  task automatic build_model();
    logic [31:0] r [32];
    logic [31:0] ins, imm, a, w, v;
    logic [1:0] sz;
    logic st;
    for (int i = 0; i < 32; i++) r[i] = '0;
    ntx = 0;
    for (int i = 0; i < NP; i++) begin
      ins = prog[i];
      if (ins[6:0] == OP_LOAD || ins[6:0] == OP_STORE) begin
        st = ins[6:0] == OP_STORE;
        imm = st ? {{20{ins[31]}}, ins[31:25], ins[11:7]} : {{20{ins[31]}}, ins[31:20]};
        sz = ins[13:12];
        a = r[ins[19:15]] + imm;
        a = sz == 2'd0 ? a : sz == 2'd1 ? a & ~32'd1 : a & ~32'd3;
        ta[ntx] = a;
        tsz[ntx] = sz;
        tw[ntx] = st;
        terr[ntx] = ntx >= 8 && $urandom_range(7) == 0;
        td[ntx] = '0;
        if (st) begin
          v = r[ins[24:20]];
          td[ntx] = sz == 2'd0 ? {4{v[7:0]}} : sz == 2'd1 ? {2{v[15:0]}} : v;
          mmem[a >> 2] = merge(mrd(1'b0, a >> 2), td[ntx], a, sz);
        end else begin
          w = mrd(1'b0, a >> 2) >> (8 * a[1:0]);
          v = sz == 2'd0 ? w & 32'hFF : sz == 2'd1 ? w & 32'hFFFF : w;
          if (!ins[14] && sz == 2'd0 && v >= 32'd128) v = v - 32'd256;
          if (!ins[14] && sz == 2'd1 && v >= 32'd32768) v = v - 32'd65536;
          if (!terr[ntx] && ins[11:7] != 5'd0) r[ins[11:7]] = v;
        end
        ntx++;
      end
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_pc"}, pc_addr, 32'd0);
    check({p, "_imcmd"}, im_command, BUS_NONE);
    check({p, "_htrans"}, bus.HTRANS, HTRANS_IDLE);
    check({p, "_haddr"}, bus.HADDR, 32'd0);
    check({p, "_hsize"}, bus.HSIZE, 32'd2);
    check({p, "_hwrite"}, bus.HWRITE, 32'd0);
    check({p, "_if_valid"}, if_valid_inst_out, 32'd0);
    check({p, "_if_id_valid"}, if_id_valid_inst, 32'd0);
    check({p, "_id_rf_valid"}, id_rf_valid_inst, 32'd0);
    check({p, "_id_rf_pc"}, id_rf_PC, 32'd0);
    check({p, "_id_rf_ir"}, id_rf_IR, NOP_INST);
  endtask

  initial begin
    checks = 0; failures = 0; idx = 0; di = 0; done = 0; lows = 0; dv = 1'b0; pc_exp = '0;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
    gen_program();
    build_model();
    @(negedge HCLK);
    @(negedge HCLK);
    #1 check_reset("rst");
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int cyc = 0; cyc < 3000 && done < ntx; cyc++) begin
      stall = dv && lows < 3 && $urandom_range(3) == 0;
      lows = stall ? lows + 1 : 0;
      bus.HREADY = !stall;
      bus.HRESP = dv && !stall && terr[di];
      bus.HRDATA = dv && !tw[di] ? mrd(1'b1, ta[di] >> 2) : $urandom;
      #1;
      check("pc_addr", pc_addr, pc_exp);
      check("im_command", im_command, stall ? BUS_NONE : BUS_LOAD);
      if (cyc == 0) check("if_id_valid_c0", if_id_valid_inst, 32'd0);
      if (cyc == 1) check("id_rf_valid_c1", id_rf_valid_inst, 32'd0);
      if (cyc >= 2) begin
        check("id_rf_valid", id_rf_valid_inst, 32'd1);
        check("id_rf_pc", id_rf_PC, pc_exp - 32'd8);
        check("id_rf_ir", id_rf_IR, exp_ir(pc_exp - 32'd8));
      end
      if (dv && !stall) begin
        if (tw[di]) begin
          check($sformatf("hwdata_%0d", di), bus.HWDATA, td[di]);
          smem[ta[di] >> 2] = merge(mrd(1'b1, ta[di] >> 2), bus.HWDATA, ta[di], tsz[di]);
        end
        done++;
      end
      if (!stall) begin
        dv = bus.HTRANS == HTRANS_NONSEQ;
        if (dv) begin
          check("tx_in_range", idx < ntx, 32'd1);
          dv = idx < ntx;
        end else check("htrans_idle", bus.HTRANS, HTRANS_IDLE);
        if (dv) begin
          di = idx;
          idx++;
          check($sformatf("haddr_%0d", di), bus.HADDR, ta[di]);
          check($sformatf("hsize_%0d", di), bus.HSIZE, {30'd0, tsz[di]});
          check($sformatf("hwrite_%0d", di), bus.HWRITE, tw[di]);
        end
        pc_exp += 32'd4;
      end
      @(negedge HCLK);
    end
    check("tx_done", done, ntx);
    HRESETn = 1'b0;
    bus.HREADY = 1'b1;
    bus.HRESP = 1'b0;
    prog[0] = enc_ld(3'd2, 5'd5, 5'd0, 12'd8);
    for (int i = 1; i < NP; i++) prog[i] = NOP_INST;
    #1 check_reset("rst2");
    @(negedge HCLK);
    HRESETn = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge HCLK);
      #1 seen = bus.HTRANS == HTRANS_NONSEQ;
    end
    check("mid_seen", seen, 32'd1);
    check("mid_pc_issue", pc_addr, 32'd8);
    @(negedge HCLK);
    bus.HREADY = 1'b0;
    #1;
    check("stall_imcmd", im_command, BUS_NONE);
    check("stall_pc0", pc_addr, 32'd12);
    check("stall_id_rf_pc0", id_rf_PC, 32'd4);
    @(negedge HCLK);
    #1;
    check("stall_pc1", pc_addr, 32'd12);
    check("stall_id_rf_pc1", id_rf_PC, 32'd4);
    HRESETn = 1'b0;
    #1 check_reset("midrst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
